hazard_stall_ctrl: RTL and testbench

Pipeline controller for the five-stage ARM core: it generates the freeze, bubble and flush controls that the IF, ID, EXE, MEM and WB stage registers consume, which are today tied to constant 0. It detects read-after-write hazards between the ID stage and the EXE/MEM stages. It flushes wrong-path instructions on a taken branch. It sequences multi-cycle data-memory accesses with a request/ready wait FSM, a timeout, and a saturating stall-cycle counter.

---
 rtl/hazard_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Purpose : pipeline hazard/flush/stall controller for the 5-stage core; HAZARD_FORWARD_EN selects load-use-only hazard detection.
// Latency : freeze/id_bubble/flush/pipe_stall are combinational (0 cycles); mem_timeout and stall_count are registered (1 cycle).
// Backpres: a pending data-memory access holds the whole pipe via pipe_stall; a timeout parks the pipe in ERR until rst.
module hazard_stall_ctrl #(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             two_src,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             freeze,
   output logic             id_bubble,
   output logic             flush,
   output logic             pipe_stall,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count
);

   // wait_cnt never exceeds TIMEOUT_CYCLES-1, so clog2 of the limit is enough.
   localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;

   logic exe_match;
   logic haz;
   logic mem_busy;

   // Source-versus-EXE destination compare; register 0 is a real register.
   always_comb begin
      exe_match = (src1 == exe_dest) | (two_src & (src2 == exe_dest));
   end

`ifdef HAZARD_FORWARD_EN
   // Forwarding covers ALU results from EXE and everything in MEM; only a load in EXE must wait.
   logic unused_mem_fields;
   assign unused_mem_fields = mem_wb_en ^ (^mem_dest);

   always_comb begin
      haz = exe_mem_r_en & exe_wb_en & exe_match;
   end
`else
   // Without forwarding any pending write to a source register in EXE or MEM blocks ID.
   logic mem_match;
   logic unused_load_flag;
   assign unused_load_flag = exe_mem_r_en;

   always_comb begin
      mem_match = (src1 == mem_dest) | (two_src & (src2 == mem_dest));
      haz       = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
   end
`endif

   // Memory stall: a request that is not completing now, or a dead memory in ERR.
   always_comb begin
      mem_busy   = mem_req & ~mem_ready;
      pipe_stall = ~rst & (mem_busy | (state == ERR));
   end

   // Priority: a global stall masks everything (EXE is held, so a branch is re-presented);
   // a taken branch beats a hazard so the PC takes the target instead of freezing.
   always_comb begin
      flush     = 1'b0;
      freeze    = 1'b0;
      id_bubble = 1'b0;
      if (!rst && !pipe_stall) begin
         if (branch_taken) begin
            flush = 1'b1;
         end else begin
            freeze    = haz;
            id_bubble = haz;
         end
      end
   end

   // Memory-wait FSM: counts consecutive stalled cycles and latches the sticky timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_busy) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               // A completed access or a withdrawn request both end the wait.
               if (mem_ready || !mem_req) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_LAST) begin
                  state       <= ERR;
                  mem_timeout <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            ERR: begin
               state <= ERR;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   // Saturating count of cycles in which the front end or the whole pipe was held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= '0;
      end else if ((freeze | pipe_stall) && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Purpose : randomized plus directed self-checking bench for hazard_stall_ctrl against a behavioural model.
// Latency : model predicts combinational outputs each cycle and registered outputs one edge later.
// Backpres: n/a (bench drives all inputs directly).
module tb_hazard_stall_ctrl;

   localparam int T  = 4;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    src1, src2, exe_dest, mem_dest;
   logic          two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic          branch_taken, mem_req, mem_ready;
   logic          freeze, id_bubble, flush, pipe_stall, mem_timeout;
   logic [CW-1:0] stall_count;

   int checks   = 0;
   int failures = 0;

   // Model state: consecutive stalled edges, timed-out flag, stall cycles seen.
   int m_run = 0;
   bit m_err = 1'b0;
   int m_cnt = 0;
   bit e_freeze, e_bubble, e_flush, e_stall;

   hazard_stall_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .src1         (src1),
      .src2         (src2),
      .two_src      (two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .branch_taken (branch_taken),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .freeze       (freeze),
      .id_bubble    (id_bubble),
      .flush        (flush),
      .pipe_stall   (pipe_stall),
      .mem_timeout  (mem_timeout),
      .stall_count  (stall_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   function automatic bit model_haz();
      bit m_exe, m_mem;
      m_exe = (src1 == exe_dest) || (two_src && (src2 == exe_dest));
      m_mem = (src1 == mem_dest) || (two_src && (src2 == mem_dest));
`ifdef HAZARD_FORWARD_EN
      m_mem = 1'b0;
      return exe_mem_r_en && exe_wb_en && m_exe;
`else
      return (exe_wb_en && m_exe) || (mem_wb_en && m_mem);
`endif
   endfunction

   task automatic model_expect();
      e_freeze = 0; e_bubble = 0; e_flush = 0; e_stall = 0;
      if (!rst) begin
         e_stall = m_err || (mem_req && !mem_ready);
         if (!e_stall) begin
            if (branch_taken) e_flush = 1;
            else begin
               e_freeze = model_haz();
               e_bubble = e_freeze;
            end
         end
      end
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic cycle(input string tag);
      #1;
      if (rst) begin
         m_run = 0; m_err = 0; m_cnt = 0;
      end
      model_expect();
      check_eq({tag, ".freeze"},      freeze,      e_freeze);
      check_eq({tag, ".id_bubble"},   id_bubble,   e_bubble);
      check_eq({tag, ".flush"},       flush,       e_flush);
      check_eq({tag, ".pipe_stall"},  pipe_stall,  e_stall);
      check_eq({tag, ".mem_timeout"}, mem_timeout, m_err);
      check_eq({tag, ".stall_count"}, stall_count, m_cnt);
      @(posedge clk);
      if (!rst) begin
         if ((e_freeze || e_stall) && m_cnt < CMAX) m_cnt++;
         if (!m_err) begin
            if (mem_req && !mem_ready) begin
               m_run++;
               if (m_run == T) m_err = 1;
            end else begin
               m_run = 0;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      src1 = 4'd15; src2 = 4'd14; two_src = 0;
      exe_dest = 4'd0; exe_wb_en = 0; exe_mem_r_en = 0;
      mem_dest = 4'd1; mem_wb_en = 0;
      branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      #1;
      check_eq("rst.outs", {freeze, id_bubble, flush, pipe_stall, mem_timeout}, 0);
      check_eq("rst.count", stall_count, 0);
      cycle("rst");
      rst = 0;
   endtask

   initial begin
      idle();
      @(negedge clk);
      do_reset();

`ifndef HAZARD_FORWARD_EN
      src1 = 3; exe_dest = 3; exe_wb_en = 1;
      #1 check_eq("nofwd.exe_hit", {freeze, id_bubble}, 2'b11);
      cycle("nofwd_exe");
      check_eq("nofwd.count1", stall_count, 1);
      exe_wb_en = 0; mem_dest = 3; mem_wb_en = 1;
      #1 check_eq("nofwd.mem_hit", freeze, 1);
      cycle("nofwd_mem");
      src1 = 7; src2 = 3; two_src = 0;
      #1 check_eq("nofwd.src2_ignored", freeze, 0);
      cycle("nofwd_src2_off");
      two_src = 1;
      #1 check_eq("nofwd.src2_used", freeze, 1);
      cycle("nofwd_src2_on");
`else
      exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 5; src1 = 0; src2 = 5; two_src = 1;
      #1 check_eq("fwd.load_use", freeze, 1);
      cycle("fwd_load");
      exe_mem_r_en = 0;
      #1 check_eq("fwd.alu_fwd", freeze, 0);
      cycle("fwd_alu");
      exe_mem_r_en = 1; exe_dest = 9; mem_dest = 5; mem_wb_en = 1;
      #1 check_eq("fwd.mem_only", freeze, 0);
      cycle("fwd_mem");
`endif

      // Branch beats hazard.
      idle();
      src1 = 2; exe_dest = 2; exe_wb_en = 1; exe_mem_r_en = 1; branch_taken = 1;
      #1 check_eq("br.flush_frz_bub", {flush, freeze, id_bubble}, 3'b100);
      cycle("branch");

      // Memory wait, 3 stalled cycles, branch masked throughout.
      do_reset();
      mem_req = 1; branch_taken = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check_eq("mw.stall_noflush", {pipe_stall, flush}, 2'b10);
         cycle("memwait");
      end
      mem_ready = 1;
      #1 check_eq("mw.ready_nostall", pipe_stall, 0);
      cycle("memready");
      check_eq("mw.count3", stall_count, 3);
      idle();
      cycle("mw_idle");

      // Timeout.
      do_reset();
      mem_req = 1;
      for (int i = 0; i < T; i++) begin
         #1 check_eq("to.not_yet", mem_timeout, 0);
         cycle("to_wait");
      end
      #1 check_eq("to.flag_stall", {mem_timeout, pipe_stall}, 2'b11);
      mem_ready = 1;
      for (int i = 0; i < 2; i++) begin
         #1 check_eq("to.sticky", {mem_timeout, pipe_stall}, 2'b11);
         cycle("to_sticky");
      end
      rst = 1;
      #1 check_eq("to.rst_clears", {freeze, id_bubble, flush, pipe_stall, mem_timeout}, 0);
      cycle("to_rst");
      rst = 0;
      idle();

      // Abort then a fresh wait that must not inherit the old count.
      do_reset();
      mem_req = 1;
      cycle("ab_wait");
      mem_req = 0;
      #1 check_eq("ab.no_stall", pipe_stall, 0);
      cycle("ab_drop");
      mem_req = 1;
      for (int i = 0; i < T - 1; i++) cycle("ab_rewait");
      check_eq("ab.no_timeout", mem_timeout, 0);
      idle();
      cycle("ab_idle");

      // Saturation.
      do_reset();
      src1 = 1; exe_dest = 1; exe_wb_en = 1; exe_mem_r_en = 1;
      for (int i = 0; i < 20; i++) cycle("sat");
      check_eq("sat.count15", stall_count, 15);
      idle();

      // Random.
      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 59) == 0);
         src1         = 4'($urandom_range(0, 3));
         src2         = 4'($urandom_range(0, 3));
         two_src      = 1'($urandom_range(0, 1));
         exe_dest     = 4'($urandom_range(0, 3));
         exe_wb_en    = 1'($urandom_range(0, 1));
         exe_mem_r_en = 1'($urandom_range(0, 1));
         mem_dest     = 4'($urandom_range(0, 3));
         mem_wb_en    = 1'($urandom_range(0, 1));
         branch_taken = ($urandom_range(0, 3) == 0);
         mem_req      = ($urandom_range(0, 2) != 0);
         mem_ready    = ($urandom_range(0, 3) == 0);
         cycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
